// File: rtl/viterbi_channel.sv
// Channel model between convolutional encoder and Viterbi decoder: registers each
// 2-bit symbol, optionally corrupts it (periodic / random / burst) and keeps error statistics.
module viterbi_channel #(
  parameter int          N         = 4,
  parameter int          WINDOW    = 256,
  parameter int          BURST_LEN = 2,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear_i,
  input  logic [1:0]  mode_i,
  input  logic [1:0]  err_mask_i,
  input  logic        valid_i,
  input  logic [1:0]  sym_i,
  output logic        valid_o,
  output logic [1:0]  sym_o,
  output logic        err_o,
  output logic [15:0] word_ct_o,
  output logic [15:0] err_ct_o,
  output logic [15:0] bad_bit_ct_o,
  output logic        window_done_o
);

  localparam logic [15:0] WIN    = WINDOW[15:0];
  localparam logic [15:0] WIN_M1 = 16'(WINDOW - 1);
  localparam logic [N:0]  BL     = BURST_LEN[N:0];

  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [1:0] inc);
    logic [16:0] s;
    s = {1'b0, a} + {15'd0, inc};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  function automatic logic [1:0] popcnt2(input logic [1:0] m);
    return {1'b0, m[1]} + {1'b0, m[0]};
  endfunction

  // Fibonacci form, taps 16,14,13,11, shifting toward bit 0
  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
  endfunction

  logic [15:0] lfsr;
  logic [15:0] word_ct, err_ct, bad_ct;
  logic        wdone;
  logic        vld_p1, err_p1;
  logic [1:0]  sym_p1;
  logic        hit;
  logic        err_hit;
  logic [1:0]  flip;

  // stage 0: corruption decision on the pre-increment word count
  always_comb begin
    hit = 1'b0;
    if (word_ct < WIN) begin
      case (mode_i)
        2'b01:   hit = &word_ct[N-1:0];
        2'b10:   hit = (lfsr[N-1:0] == '0);
        2'b11:   hit = ({1'b0, word_ct[N-1:0]} < BL);
        default: hit = 1'b0;
      endcase
    end
    flip    = hit ? err_mask_i : 2'b00;
    err_hit = hit && (err_mask_i != 2'b00);
  end

  // stage 1: registered symbol and statistics
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      sym_p1  <= 2'b00;
      err_p1  <= 1'b0;
      word_ct <= '0;
      err_ct  <= '0;
      bad_ct  <= '0;
      wdone   <= 1'b0;
      lfsr    <= LFSR_SEED;
    end else if (clear_i) begin
      vld_p1  <= 1'b0;
      word_ct <= '0;
      err_ct  <= '0;
      bad_ct  <= '0;
      wdone   <= 1'b0;
      lfsr    <= LFSR_SEED;
    end else if (valid_i) begin
      vld_p1  <= 1'b1;
      sym_p1  <= sym_i ^ flip;
      err_p1  <= err_hit;
      word_ct <= sat_add(word_ct, 2'd1);
      err_ct  <= sat_add(err_ct, {1'b0, err_hit});
      bad_ct  <= sat_add(bad_ct, popcnt2(flip));
      lfsr    <= lfsr_step(lfsr);
      if (word_ct == WIN_M1) wdone <= 1'b1;
    end else begin
      vld_p1  <= 1'b0;
    end
  end

  assign valid_o       = vld_p1;
  assign sym_o         = sym_p1;
  assign err_o         = err_p1;
  assign word_ct_o     = word_ct;
  assign err_ct_o      = err_ct;
  assign bad_bit_ct_o  = bad_ct;
  assign window_done_o = wdone;

endmodule

// File: tb/tb_viterbi_channel.sv
// Directed self-checking bench for viterbi_channel: a behavioural channel model
// plus hand-computed totals for the periodic and burst patterns.
module tb_viterbi_channel;

  localparam int N         = 4;
  localparam int WINDOW    = 256;
  localparam int BURST_LEN = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear_i = 1'b0;
  logic [1:0]  mode_i = 2'b00;
  logic [1:0]  err_mask_i = 2'b00;
  logic        valid_i = 1'b0;
  logic [1:0]  sym_i = 2'b00;
  logic        valid_o;
  logic [1:0]  sym_o;
  logic        err_o;
  logic [15:0] word_ct_o, err_ct_o, bad_bit_ct_o;
  logic        window_done_o;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  int unsigned m_word, m_err, m_bad, m_lfsr;
  bit          m_wdone, e_vld, e_err;
  logic [1:0]  e_sym;

  viterbi_channel #(.N(N), .WINDOW(WINDOW), .BURST_LEN(BURST_LEN), .LFSR_SEED(16'hACE1)) dut (
    .clk(clk), .rst(rst), .clear_i(clear_i), .mode_i(mode_i), .err_mask_i(err_mask_i),
    .valid_i(valid_i), .sym_i(sym_i), .valid_o(valid_o), .sym_o(sym_o), .err_o(err_o),
    .word_ct_o(word_ct_o), .err_ct_o(err_ct_o), .bad_bit_ct_o(bad_bit_ct_o),
    .window_done_o(window_done_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    m_word = 0; m_err = 0; m_bad = 0; m_lfsr = 32'hACE1; m_wdone = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".valid_o"}, {15'd0, valid_o}, {15'd0, e_vld});
    chk({tag, ".sym_o"}, {14'd0, sym_o}, {14'd0, e_sym});
    chk({tag, ".err_o"}, {15'd0, err_o}, {15'd0, e_err});
    chk({tag, ".word_ct"}, word_ct_o, m_word[15:0]);
    chk({tag, ".err_ct"}, err_ct_o, m_err[15:0]);
    chk({tag, ".bad_ct"}, bad_bit_ct_o, m_bad[15:0]);
    chk({tag, ".wdone"}, {15'd0, window_done_o}, {15'd0, m_wdone});
  endtask

  // one clock: drive, update model, clock, check
  task automatic send(input string tag, input bit v, input logic [1:0] s,
                      input logic [1:0] md, input logic [1:0] mk, input bit clr);
    bit hit;
    int unsigned ph, fb;
    clear_i = clr; valid_i = v; sym_i = s; mode_i = md; err_mask_i = mk;
    if (clr) begin
      model_reset();
      e_vld = 0;
    end else if (v) begin
      ph  = m_word % (1 << N);
      hit = 0;
      if (m_word < WINDOW) begin
        if (md == 2'b01) hit = (ph == (1 << N) - 1);
        if (md == 2'b10) hit = ((m_lfsr % (1 << N)) == 0);
        if (md == 2'b11) hit = (ph < BURST_LEN);
      end
      e_vld = 1;
      e_sym = hit ? (s ^ mk) : s;
      e_err = hit && (mk != 2'b00);
      if (e_err && m_err < 65535) m_err++;
      if (hit) m_bad = m_bad + mk[0] + mk[1];
      if (m_bad > 65535) m_bad = 65535;
      if (m_word < 65535) m_word++;
      if (m_word == WINDOW) m_wdone = 1;
      fb = ((m_lfsr >> 0) ^ (m_lfsr >> 2) ^ (m_lfsr >> 3) ^ (m_lfsr >> 5)) & 1;
      m_lfsr = (m_lfsr >> 1) | (fb << 15);
    end else begin
      e_vld = 0;
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    model_reset();
    e_vld = 0; e_sym = 2'b00; e_err = 0;
    repeat (3) @(posedge clk);
    #1;
    check_all("reset");
    rst = 1'b0;

    // 1: clean pass-through, window flag at word 256
    for (int i = 0; i < 300; i++) begin
      send("clean", 1'b1, 2'($urandom_range(0, 3)), 2'b00, 2'b11, 1'b0);
      if (i == 254) chk("wdone_before", {15'd0, window_done_o}, 16'd0);
      if (i == 255) chk("wdone_at", {15'd0, window_done_o}, 16'd1);
    end
    chk("clean.err_total", err_ct_o, 16'd0);
    send("clear_drop", 1'b1, 2'b10, 2'b00, 2'b00, 1'b1);

    // 2: periodic, past the window to confirm injection stops at word 256
    for (int i = 0; i < 288; i++) begin
      send("periodic", 1'b1, 2'(i), 2'b01, 2'b01, 1'b0);
      chk("periodic.hand_err", {15'd0, err_o}, {15'd0, ((i % 16) == 15) && (i < 256)});
    end
    chk("periodic.err_total", err_ct_o, 16'd16);
    chk("periodic.bad_total", bad_bit_ct_o, 16'd16);
    send("clear2", 1'b0, 2'b00, 2'b00, 2'b00, 1'b1);

    // 3: burst of two words per 16-word period, both bits flipped
    for (int i = 0; i < 64; i++) send("burst", 1'b1, 2'b01, 2'b11, 2'b11, 1'b0);
    chk("burst.err_total", err_ct_o, 16'd8);
    chk("burst.bad_total", bad_bit_ct_o, 16'd16);
    send("clear3", 1'b0, 2'b00, 2'b00, 2'b00, 1'b1);

    // 4: pseudo-random injection against the LFSR model
    for (int i = 0; i < 256; i++) send("random", 1'b1, 2'($urandom_range(0, 3)), 2'b10, 2'b10, 1'b0);
    chk("random.bad_eq_err", bad_bit_ct_o, err_ct_o);
    send("clear4", 1'b0, 2'b00, 2'b00, 2'b00, 1'b1);

    // 5: 1-on/3-off gaps; pattern follows accepted words only
    for (int i = 0; i < 160; i++) send("gaps", (i % 4) == 0, 2'b00, 2'b01, 2'b01, 1'b0);
    chk("gaps.word_total", word_ct_o, 16'd40);
    chk("gaps.err_total", err_ct_o, 16'd2);
    send("clear5", 1'b0, 2'b00, 2'b00, 2'b00, 1'b1);

    // hits with a zero mask are not errors
    for (int i = 0; i < 32; i++) send("mask0", 1'b1, 2'b11, 2'b01, 2'b00, 1'b0);
    chk("mask0.err_total", err_ct_o, 16'd0);
    chk("mask0.bad_total", bad_bit_ct_o, 16'd0);
    send("clear6", 1'b0, 2'b00, 2'b00, 2'b00, 1'b1);

    // 6: async reset at word 100, then clear mid-stream restarts the LFSR
    for (int i = 0; i < 100; i++) send("pre_rst", 1'b1, 2'b10, 2'b01, 2'b11, 1'b0);
    valid_i = 1'b1;
    #2 rst = 1'b1;
    #1;
    model_reset();
    e_vld = 0; e_sym = 2'b00; e_err = 0;
    check_all("async_rst");
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 50; i++) send("post_rst", 1'b1, 2'($urandom_range(0, 3)), 2'b10, 2'b01, 1'b0);
    send("mid_clear", 1'b1, 2'b11, 2'b10, 2'b01, 1'b1);
    for (int i = 0; i < 40; i++) send("post_clear", 1'b1, 2'($urandom_range(0, 3)), 2'b10, 2'b01, 1'b0);
    send("idle", 1'b0, 2'b00, 2'b00, 2'b00, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
